// File: rtl/id_stage_pkg.sv
// Shared RV32I decode vocabulary: operation encodings, the stage control bundle,
// opcode/funct constants and the immediate-format selector.
package id_stage_pkg;

    localparam int DATA_WIDTH_ALU_OP  = 5;
    localparam int DATA_WIDTH_MEM_OP  = 4;
    localparam int DATA_WIDTH_CTRL_OP = 2;
    localparam int DATA_WIDTH_ISA_EXP = 2;

    typedef enum logic [DATA_WIDTH_ALU_OP-1:0] {
        ALU_OP_NOP    = 5'd0,
        ALU_OP_ADD    = 5'd1,
        ALU_OP_SUB    = 5'd2,
        ALU_OP_SLT    = 5'd3,
        ALU_OP_SLTU   = 5'd4,
        ALU_OP_XOR    = 5'd5,
        ALU_OP_OR     = 5'd6,
        ALU_OP_AND    = 5'd7,
        ALU_OP_SLL    = 5'd8,
        ALU_OP_SRL    = 5'd9,
        ALU_OP_SRA    = 5'd10,
        ALU_OP_MUL    = 5'd11,
        ALU_OP_MULH   = 5'd12,
        ALU_OP_MULHSU = 5'd13,
        ALU_OP_MULHU  = 5'd14,
        ALU_OP_DIV    = 5'd15,
        ALU_OP_DIVU   = 5'd16,
        ALU_OP_REM    = 5'd17,
        ALU_OP_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [DATA_WIDTH_MEM_OP-1:0] {
        MEM_OP_NOP      = 4'd0,
        MEM_OP_LOAD_LW  = 4'd1,
        MEM_OP_LOAD_LH  = 4'd2,
        MEM_OP_LOAD_LB  = 4'd3,
        MEM_OP_LOAD_LHU = 4'd4,
        MEM_OP_LOAD_LBU = 4'd5,
        MEM_OP_STORE_SW = 4'd6,
        MEM_OP_STORE_SH = 4'd7,
        MEM_OP_STORE_SB = 4'd8
    } mem_op_e;

    typedef enum logic [DATA_WIDTH_CTRL_OP-1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_JAL  = 2'd1,
        CTRL_OP_JALR = 2'd2,
        CTRL_OP_BR   = 2'd3
    } ctrl_op_e;

    typedef enum logic [DATA_WIDTH_ISA_EXP-1:0] {
        ISA_EXP_NO_EXP     = 2'd0,
        ISA_EXP_UNDEF_INSN = 2'd1,
        ISA_EXP_MISALIGN   = 2'd2
    } isa_exp_e;

    typedef enum logic [2:0] {
        IMM_FMT_NONE = 3'd0,
        IMM_FMT_I    = 3'd1,
        IMM_FMT_S    = 3'd2,
        IMM_FMT_B    = 3'd3,
        IMM_FMT_U    = 3'd4,
        IMM_FMT_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e  alu_op;
        mem_op_e  mem_op;
        ctrl_op_e ctrl_op;
        isa_exp_e exp_code;
        logic     gpr_we_;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op:   ALU_OP_NOP,
        mem_op:   MEM_OP_NOP,
        ctrl_op:  CTRL_OP_NOP,
        exp_code: ISA_EXP_NO_EXP,
        gpr_we_:  1'b1
    };

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic [31:0] imm32(input logic [31:0] insn, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_FMT_I: imm = {{20{insn[31]}}, insn[31:20]};
            IMM_FMT_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_FMT_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_FMT_U: imm = {insn[31:12], 12'b0};
            IMM_FMT_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default:   imm = 32'b0;
        endcase
        return imm;
    endfunction

    // funct3 -> ALU op shared by OP and OP_IMM; 101 is refined to SRA by funct7.
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_OP_ADD;
            3'b001:  op = ALU_OP_SLL;
            3'b010:  op = ALU_OP_SLT;
            3'b011:  op = ALU_OP_SLTU;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = ALU_OP_SRL;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_OP_LOAD_LW) || (op == MEM_OP_LOAD_LH) || (op == MEM_OP_LOAD_LB) ||
               (op == MEM_OP_LOAD_LHU) || (op == MEM_OP_LOAD_LBU);
    endfunction

endpackage

// File: rtl/id_stage_decode.sv
// Combinational RV32I decode: instruction + PC + operands -> control bundle, operands,
// rs-use flags and control-transfer outcome. SIICPU_RV32M_EN adds the M-extension ops.
module id_decode_comb
    import id_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int GPR_AW   = 5,
    parameter int BR_ALIGN = 2
) (
    input  logic [31:0]       insn,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output ctrl_t             ctrl,
    output logic [XLEN-1:0]   alu_in_0,
    output logic [XLEN-1:0]   alu_in_1,
    output logic [XLEN-1:0]   gpr_data,
    output logic [GPR_AW-1:0] dst_addr,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              taken,
    output logic [XLEN-1:0]   target
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << BR_ALIGN) - 64'd1);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    imm_fmt_e        fmt_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] rs1_sum;
    logic            br_cond;
    logic            br_fn_ok;
    logic            undef;
    logic            xfer;

    assign opcode  = insn[6:0];
    assign funct3  = insn[14:12];
    assign funct7  = insn[31:25];
    assign imm     = XLEN'($signed(imm32(insn, fmt_sel)));
    assign pc_sum  = pc + imm;
    assign rs1_sum = rs1_data + imm;

    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC:            fmt_sel = IMM_FMT_U;
            OPC_JAL:                       fmt_sel = IMM_FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt_sel = IMM_FMT_I;
            OPC_STORE:                     fmt_sel = IMM_FMT_S;
            OPC_BRANCH:                    fmt_sel = IMM_FMT_B;
            default:                       fmt_sel = IMM_FMT_NONE;
        endcase
    end

    always_comb begin
        br_cond  = 1'b0;
        br_fn_ok = 1'b1;
        case (funct3)
            3'b000:  br_cond = (rs1_data == rs2_data);
            3'b001:  br_cond = (rs1_data != rs2_data);
            3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_cond = (rs1_data <  rs2_data);
            3'b111:  br_cond = (rs1_data >= rs2_data);
            default: br_fn_ok = 1'b0;
        endcase
    end

    always_comb begin
        ctrl     = CTRL_NOP;
        alu_in_0 = rs1_data;
        alu_in_1 = rs2_data;
        gpr_data = rs2_data;
        dst_addr = GPR_AW'(insn[11:7]);
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        undef    = 1'b0;
        xfer     = 1'b0;
        target   = pc_sum;

        case (opcode)
            OPC_LUI: begin
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.gpr_we_ = 1'b0;
                alu_in_0     = imm;
                alu_in_1     = '0;
            end
            OPC_AUIPC: begin
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.gpr_we_ = 1'b0;
                alu_in_0     = imm;
                alu_in_1     = pc;
            end
            OPC_JAL: begin
                ctrl.ctrl_op = CTRL_OP_JAL;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.gpr_we_ = 1'b0;
                alu_in_0     = pc;
                alu_in_1     = XLEN'(4);
                xfer         = 1'b1;
            end
            OPC_JALR: begin
                use_rs1      = 1'b1;
                undef        = (funct3 != 3'b000);
                ctrl.ctrl_op = CTRL_OP_JALR;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.gpr_we_ = 1'b0;
                alu_in_0     = pc;
                alu_in_1     = XLEN'(4);
                xfer         = 1'b1;
                target       = rs1_sum & ~XLEN'(1);
            end
            OPC_BRANCH: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                undef        = !br_fn_ok;
                ctrl.ctrl_op = CTRL_OP_BR;
                dst_addr     = '0;
                xfer         = br_cond;
            end
            OPC_LOAD: begin
                use_rs1      = 1'b1;
                ctrl.alu_op  = ALU_OP_ADD;
                ctrl.gpr_we_ = 1'b0;
                alu_in_1     = imm;
                case (funct3)
                    3'b000:  ctrl.mem_op = MEM_OP_LOAD_LB;
                    3'b001:  ctrl.mem_op = MEM_OP_LOAD_LH;
                    3'b010:  ctrl.mem_op = MEM_OP_LOAD_LW;
                    3'b100:  ctrl.mem_op = MEM_OP_LOAD_LBU;
                    3'b101:  ctrl.mem_op = MEM_OP_LOAD_LHU;
                    default: undef = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                ctrl.alu_op = ALU_OP_ADD;
                alu_in_1    = imm;
                dst_addr    = '0;
                case (funct3)
                    3'b000:  ctrl.mem_op = MEM_OP_STORE_SB;
                    3'b001:  ctrl.mem_op = MEM_OP_STORE_SH;
                    3'b010:  ctrl.mem_op = MEM_OP_STORE_SW;
                    default: undef = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                // Immediate forms carry the immediate (or shamt) on operand 0, rs1 on operand 1.
                use_rs1      = 1'b1;
                ctrl.gpr_we_ = 1'b0;
                ctrl.alu_op  = base_alu_op(funct3);
                alu_in_0     = imm;
                alu_in_1     = rs1_data;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    alu_in_0 = XLEN'(insn[24:20]);
                    if (funct3 == 3'b101 && funct7 == FUNCT7_ALT) begin
                        ctrl.alu_op = ALU_OP_SRA;
                    end else if (funct7 != FUNCT7_BASE) begin
                        undef = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                ctrl.gpr_we_ = 1'b0;
                case (funct7)
                    FUNCT7_BASE: ctrl.alu_op = base_alu_op(funct3);
                    FUNCT7_ALT: begin
                        if (funct3 == 3'b000) begin
                            ctrl.alu_op = ALU_OP_SUB;
                        end else if (funct3 == 3'b101) begin
                            ctrl.alu_op = ALU_OP_SRA;
                        end else begin
                            undef = 1'b1;
                        end
                    end
`ifdef SIICPU_RV32M_EN
                    FUNCT7_MULDIV: ctrl.alu_op = alu_op_e'(ALU_OP_MUL + DATA_WIDTH_ALU_OP'(funct3));
`endif
                    default: undef = 1'b1;
                endcase
            end
            OPC_MISC_MEM: dst_addr = '0;
            default:      undef = 1'b1;
        endcase

        if (undef) begin
            ctrl     = CTRL_NOP;
            ctrl.exp_code = ISA_EXP_UNDEF_INSN;
            xfer     = 1'b0;
        end else if (xfer && ((target & ALIGN_MASK) != '0)) begin
            // A faulting transfer neither redirects nor writes its link register.
            ctrl.exp_code = ISA_EXP_MISALIGN;
            ctrl.gpr_we_  = 1'b1;
            xfer          = 1'b0;
        end
        if (dst_addr == '0) begin
            ctrl.gpr_we_ = 1'b1;
        end
        taken = xfer;
    end

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: 1-cycle accept->ex_valid, one-cycle registered redirect,
// load-use interlock; a held bundle (ex_valid & !ex_ready) freezes the stage and drops if_ready.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int GPR_AW   = 5,
    parameter int BR_ALIGN = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          if_valid,
    output logic                          if_ready,
    input  logic [31:0]                   if_insn,
    input  logic [XLEN-1:0]               if_pc,
    output logic [GPR_AW-1:0]             gpr_rd_addr_0,
    output logic [GPR_AW-1:0]             gpr_rd_addr_1,
    input  logic [XLEN-1:0]               gpr_rd_data_0,
    input  logic [XLEN-1:0]               gpr_rd_data_1,
    output logic                          ex_valid,
    input  logic                          ex_ready,
    output logic [XLEN-1:0]               id_pc,
    output alu_op_e                       alu_op,
    output logic [XLEN-1:0]               alu_in_0,
    output logic [XLEN-1:0]               alu_in_1,
    output logic [GPR_AW-1:0]             dst_addr,
    output logic                          gpr_we_,
    output mem_op_e                       mem_op,
    output logic [XLEN-1:0]               gpr_data,
    output ctrl_op_e                      ctrl_op,
    output isa_exp_e                      exp_code,
    output logic                          br_taken,
    output logic [XLEN-1:0]               br_addr
);

    ctrl_t             dec_ctrl;
    logic [XLEN-1:0]   dec_alu_in_0;
    logic [XLEN-1:0]   dec_alu_in_1;
    logic [XLEN-1:0]   dec_gpr_data;
    logic [GPR_AW-1:0] dec_dst_addr;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic              dec_taken;
    logic [XLEN-1:0]   dec_target;

    ctrl_t             ctrl_q, ctrl_d;
    logic              ex_valid_q, ex_valid_d;
    logic              br_taken_q, br_taken_d;
    logic [XLEN-1:0]   br_addr_q, br_addr_d;
    logic [XLEN-1:0]   id_pc_q, id_pc_d;
    logic [XLEN-1:0]   alu_in_0_q, alu_in_0_d;
    logic [XLEN-1:0]   alu_in_1_q, alu_in_1_d;
    logic [XLEN-1:0]   gpr_data_q, gpr_data_d;
    logic [GPR_AW-1:0] dst_addr_q, dst_addr_d;

    logic advance;
    logic hazard;
    logic accept;
    logic load;

    assign gpr_rd_addr_0 = GPR_AW'(if_insn[19:15]);
    assign gpr_rd_addr_1 = GPR_AW'(if_insn[24:20]);

    id_decode_comb #(
        .XLEN     (XLEN),
        .GPR_AW   (GPR_AW),
        .BR_ALIGN (BR_ALIGN)
    ) u_decode (
        .insn     (if_insn),
        .pc       (if_pc),
        .rs1_data (gpr_rd_data_0),
        .rs2_data (gpr_rd_data_1),
        .ctrl     (dec_ctrl),
        .alu_in_0 (dec_alu_in_0),
        .alu_in_1 (dec_alu_in_1),
        .gpr_data (dec_gpr_data),
        .dst_addr (dec_dst_addr),
        .use_rs1  (dec_use_rs1),
        .use_rs2  (dec_use_rs2),
        .taken    (dec_taken),
        .target   (dec_target)
    );

    assign advance = !ex_valid_q || ex_ready;
    assign hazard  = ex_valid_q && is_load(ctrl_q.mem_op) && (dst_addr_q != '0) &&
                     ((dec_use_rs1 && (gpr_rd_addr_0 == dst_addr_q)) ||
                      (dec_use_rs2 && (gpr_rd_addr_1 == dst_addr_q)));
    assign if_ready = advance && !hazard && !flush;
    assign accept   = if_valid && if_ready;
    // The instruction offered while a redirect is out is wrong-path: consume and drop it.
    assign load     = accept && !br_taken_q;

    always_comb begin
        ctrl_d     = ctrl_q;
        ex_valid_d = ex_valid_q;
        br_taken_d = br_taken_q;
        br_addr_d  = br_addr_q;
        id_pc_d    = id_pc_q;
        alu_in_0_d = alu_in_0_q;
        alu_in_1_d = alu_in_1_q;
        gpr_data_d = gpr_data_q;
        dst_addr_d = dst_addr_q;

        if (flush) begin
            ex_valid_d = 1'b0;
            br_taken_d = 1'b0;
            ctrl_d     = CTRL_NOP;
        end else if (advance) begin
            ex_valid_d = load;
            br_taken_d = load && dec_taken;
            ctrl_d     = load ? dec_ctrl : CTRL_NOP;
            id_pc_d    = if_pc;
            alu_in_0_d = dec_alu_in_0;
            alu_in_1_d = dec_alu_in_1;
            gpr_data_d = dec_gpr_data;
            dst_addr_d = dec_dst_addr;
            if (load && dec_taken) begin
                br_addr_d = dec_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= CTRL_NOP;
            ex_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            br_addr_q  <= '0;
            id_pc_q    <= '0;
            alu_in_0_q <= '0;
            alu_in_1_q <= '0;
            gpr_data_q <= '0;
            dst_addr_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            br_taken_q <= br_taken_d;
            br_addr_q  <= br_addr_d;
            id_pc_q    <= id_pc_d;
            alu_in_0_q <= alu_in_0_d;
            alu_in_1_q <= alu_in_1_d;
            gpr_data_q <= gpr_data_d;
            dst_addr_q <= dst_addr_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign id_pc    = id_pc_q;
    assign alu_op   = ctrl_q.alu_op;
    assign mem_op   = ctrl_q.mem_op;
    assign ctrl_op  = ctrl_q.ctrl_op;
    assign exp_code = ctrl_q.exp_code;
    assign gpr_we_  = ctrl_q.gpr_we_;
    assign alu_in_0 = alu_in_0_q;
    assign alu_in_1 = alu_in_1_q;
    assign gpr_data = gpr_data_q;
    assign dst_addr = dst_addr_q;
    assign br_taken = br_taken_q;
    assign br_addr  = br_addr_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a small GPR model; expected values hand-derived from encodings.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_insn;
    logic [31:0] if_pc;
    logic [4:0]  gpr_rd_addr_0;
    logic [4:0]  gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0;
    logic [31:0] gpr_rd_data_1;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] id_pc;
    alu_op_e     alu_op;
    logic [31:0] alu_in_0;
    logic [31:0] alu_in_1;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    mem_op_e     mem_op;
    logic [31:0] gpr_data;
    ctrl_op_e    ctrl_op;
    isa_exp_e    exp_code;
    logic        br_taken;
    logic [31:0] br_addr;

    logic [31:0] gpr [32];
    int n_vec  = 0;
    int n_miss = 0;

    assign gpr_rd_data_0 = gpr[gpr_rd_addr_0];
    assign gpr_rd_data_1 = gpr[gpr_rd_addr_1];

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .GPR_AW(5), .BR_ALIGN(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_insn(if_insn), .if_pc(if_pc),
        .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .id_pc(id_pc),
        .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
        .dst_addr(dst_addr), .gpr_we_(gpr_we_), .mem_op(mem_op), .gpr_data(gpr_data),
        .ctrl_op(ctrl_op), .exp_code(exp_code), .br_taken(br_taken), .br_addr(br_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] insn, input logic [31:0] pc);
        if_valid = 1'b1;
        if_insn  = insn;
        if_pc    = pc;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        if_insn  = 32'h0000_0013;
        if_pc    = 32'h0;
    endtask

    localparam logic [31:0] ADDI_M5  = 32'hFFB0_0093; // addi x1,x0,-5
    localparam logic [31:0] LW_X2    = 32'h0000_A103; // lw   x2,0(x1)
    localparam logic [31:0] ADD_X3   = 32'h0021_01B3; // add  x3,x2,x2
    localparam logic [31:0] SW_X2    = 32'h0020_A223; // sw   x2,4(x1)
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3; // beq  x0,x0,-8
    localparam logic [31:0] BNE_M8   = 32'hFE00_1CE3; // bne  x0,x0,-8
    localparam logic [31:0] JALR_3   = 32'h0032_80E7; // jalr x1,3(x5)
    localparam logic [31:0] JAL_16   = 32'h0100_00EF; // jal  x1,+16
    localparam logic [31:0] MUL_X0   = 32'h0220_8033; // mul  x0,x1,x2

    initial begin
        for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
        gpr[1] = 32'h0000_1000;
        gpr[2] = 32'h0000_0055;
        gpr[5] = 32'h0000_0200;
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        idle();
        tick(); tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_br_addr", br_addr, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_alu_op", alu_op, ALU_OP_NOP);
        check("rst_mem_op", mem_op, MEM_OP_NOP);
        check("rst_ctrl_op", ctrl_op, CTRL_OP_NOP);
        check("rst_exp", exp_code, ISA_EXP_NO_EXP);
        check("rst_we_", gpr_we_, 1);
        rst = 1'b0;

        offer(ADDI_M5, 32'h10);
        #1 check("addi_if_ready", if_ready, 1);
        tick(); idle();
        check("addi_valid", ex_valid, 1);
        check("addi_op", alu_op, ALU_OP_ADD);
        check("addi_in0", alu_in_0, 32'hFFFF_FFFB);
        check("addi_in1", alu_in_1, 32'h0);
        check("addi_dst", dst_addr, 1);
        check("addi_we_", gpr_we_, 0);
        check("addi_pc", id_pc, 32'h10);
        tick();
        check("drain_valid", ex_valid, 0);

        offer(LW_X2, 32'h20);
        tick();
        offer(ADD_X3, 32'h24);
        #1 check("lu_if_ready_stall", if_ready, 0);
        check("lw_mem_op", mem_op, MEM_OP_LOAD_LW);
        check("lw_in0", alu_in_0, 32'h1000);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_if_ready_after", if_ready, 1);
        tick(); idle();
        check("add_valid", ex_valid, 1);
        check("add_pc", id_pc, 32'h24);
        check("add_in0", alu_in_0, 32'h55);
        check("add_in1", alu_in_1, 32'h55);
        check("add_dst", dst_addr, 3);

        offer(SW_X2, 32'h30);
        tick(); idle();
        check("sw_mem_op", mem_op, MEM_OP_STORE_SW);
        check("sw_in0", alu_in_0, 32'h1000);
        check("sw_in1", alu_in_1, 32'h4);
        check("sw_data", gpr_data, 32'h55);
        check("sw_we_", gpr_we_, 1);

        offer(BEQ_M8, 32'h100);
        tick();
        check("beq_taken", br_taken, 1);
        check("beq_addr", br_addr, 32'hF8);
        check("beq_ctrl", ctrl_op, CTRL_OP_BR);
        offer(ADDI_M5, 32'h104);
        #1 check("wp_if_ready", if_ready, 1);
        tick(); idle();
        check("beq_pulse_end", br_taken, 0);
        check("wp_dropped", ex_valid, 0);

        offer(BNE_M8, 32'h200);
        tick(); idle();
        check("bne_valid", ex_valid, 1);
        check("bne_not_taken", br_taken, 0);

        offer(JALR_3, 32'h300);
        tick(); idle();
        check("jalr_no_redirect", br_taken, 0);
        check("jalr_exp", exp_code, ISA_EXP_MISALIGN);

        offer(JAL_16, 32'hFFFF_FFF8);
        tick(); idle();
        check("jal_taken", br_taken, 1);
        check("jal_wrap_addr", br_addr, 32'h8);
        check("jal_link_in0", alu_in_0, 32'hFFFF_FFF8);
        check("jal_link_in1", alu_in_1, 32'h4);
        check("jal_we_", gpr_we_, 0);
        tick();
        check("jal_pulse_end", br_taken, 0);

        offer(32'hFFFF_FFFF, 32'h40);
        tick(); idle();
        check("undef_valid", ex_valid, 1);
        check("undef_exp", exp_code, ISA_EXP_UNDEF_INSN);
        check("undef_we_", gpr_we_, 1);
        check("undef_alu", alu_op, ALU_OP_NOP);

        offer(MUL_X0, 32'h44);
        tick(); idle();
        check("mul_we_", gpr_we_, 1);
`ifdef SIICPU_RV32M_EN
        check("mul_alu", alu_op, ALU_OP_MUL);
        check("mul_exp", exp_code, ISA_EXP_NO_EXP);
`else
        check("mul_exp", exp_code, ISA_EXP_UNDEF_INSN);
        check("mul_alu", alu_op, ALU_OP_NOP);
`endif

        offer(ADDI_M5, 32'h50);
        tick();
        ex_ready = 1'b0;
        offer(ADD_X3, 32'h54);
        #1 check("hold_if_ready", if_ready, 0);
        tick();
        check("hold_valid", ex_valid, 1);
        check("hold_pc", id_pc, 32'h50);
        check("hold_in0", alu_in_0, 32'hFFFF_FFFB);
        flush = 1'b1;
        #1 check("flush_if_ready", if_ready, 0);
        tick();
        flush = 1'b0;
        check("flush_hold_valid", ex_valid, 0);
        idle(); ex_ready = 1'b1;
        tick();

        offer(BEQ_M8, 32'h100);
        tick(); idle();
        ex_ready = 1'b0;
        tick();
        check("hold_br_taken", br_taken, 1);
        check("hold_br_addr", br_addr, 32'hF8);
        flush = 1'b1;
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        check("flush_br_taken", br_taken, 0);
        check("flush_br_valid", ex_valid, 0);

        offer(BEQ_M8, 32'h100);
        tick(); idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_br_taken", br_taken, 0);
        check("mrst_br_addr", br_addr, 0);
        check("mrst_valid", ex_valid, 0);
        check("mrst_pc", id_pc, 0);
        check("mrst_ctrl", ctrl_op, CTRL_OP_NOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
